papuf_eval_ctrl: RTL and testbench

- Initiator-side controller that drives a 16-bit PAPUF array (challenge bus plus pulse) and captures its 16-bit response.
- Accepts a challenge over a valid/ready request interface and applies it with a timed pulse NUM_EVAL times.
- Samples the asynchronous response through a 2-flop synchronizer and returns the bitwise majority vote plus an instability mask over a valid/ready response interface.
- Sits between the system bus or test host and the PUF array instances.

---
 rtl/papuf_pkg.sv | 22 ++
 rtl/papuf_eval_ctrl_if.sv | 24 ++
 rtl/papuf_resp_sync.sv | 27 ++
 rtl/papuf_eval_ctrl.sv | 134 +++++++++++++
 tb/tb_papuf_eval_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/papuf_pkg.sv
// Shared types and helpers for the PAPUF evaluation controller.
package papuf_pkg;

  localparam int unsigned PUF_WIDTH = 16;

  // Controller FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    PULSE  = 3'd2,
    SETTLE = 3'd3,
    SAMPLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Bits needed to hold any value in 0..n
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n < 2) return 1;
    return $unsigned($clog2(n + 1));
  endfunction

endpackage

// File: rtl/papuf_eval_ctrl_if.sv
// Request/response handshake bundle between the host and the evaluation controller.
interface papuf_eval_ctrl_if
  import papuf_pkg::*;
#(
  parameter int unsigned WIDTH = PUF_WIDTH
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_challenge;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [WIDTH-1:0] rsp_unstable;

  modport master (
    output req_valid, req_challenge, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_unstable
  );

  modport slave (
    input  req_valid, req_challenge, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_unstable
  );
endinterface

// File: rtl/papuf_resp_sync.sv
// Two-flop synchronizer bringing the asynchronous PUF response into the clk domain.
module papuf_resp_sync #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Metastability filter: only r_sync is used downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/papuf_eval_ctrl.sv
// Drives a PAPUF array with a challenge and timed pulses, majority-votes the
// synchronized response over NUM_EVAL evaluations and reports instability.
module papuf_eval_ctrl
  import papuf_pkg::*;
#(
  parameter int unsigned WIDTH      = PUF_WIDTH,
  parameter int unsigned NUM_EVAL   = 5,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned PULSE_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  papuf_eval_ctrl_if.slave        bus,
  output logic [WIDTH-1:0]        puf_challenge,
  output logic                    puf_pulse,
  input  logic [WIDTH-1:0]        puf_response,
  output logic                    busy
);

  localparam int unsigned CNT_W  = cnt_width(NUM_EVAL);
  localparam int unsigned PH_MAX = (SETUP_CYC > PULSE_CYC)
                                   ? ((SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC)
                                   : ((PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC);
  localparam int unsigned PH_W   = cnt_width(PH_MAX);

  state_t             r_state;
  state_t             w_state_d;
  logic [PH_W-1:0]    r_phase;
  logic               w_timed;
  logic               w_accept;
  logic               w_last;
  logic [CNT_W-1:0]   r_eval;
  logic [CNT_W-1:0]   r_cnt      [WIDTH];
  logic [CNT_W-1:0]   w_cnt_next [WIDTH];
  logic [WIDTH-1:0]   w_maj;
  logic [WIDTH-1:0]   w_unst;
  logic [WIDTH-1:0]   w_resp_sync;
  logic [WIDTH-1:0]   r_challenge;
  logic               r_pulse;
  logic               r_busy;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_data;
  logic [WIDTH-1:0]   r_rsp_unstable;

  papuf_resp_sync #(.WIDTH(WIDTH)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (puf_response),
    .o_sync  (w_resp_sync)
  );

  assign w_accept = (r_state == IDLE) && bus.req_valid && r_req_ready;
  assign w_last   = (r_eval == CNT_W'(NUM_EVAL - 1));
  assign w_timed  = (r_state == SETUP) || (r_state == PULSE) || (r_state == SETTLE);

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_d = SETUP;
      SETUP:   if (r_phase == PH_W'(SETUP_CYC - 1)) w_state_d = PULSE;
      PULSE:   if (r_phase == PH_W'(PULSE_CYC - 1)) w_state_d = SETTLE;
      SETTLE:  if (r_phase == PH_W'(SETTLE_CYC - 1)) w_state_d = SAMPLE;
      SAMPLE:  w_state_d = w_last ? DONE : SETUP;
      DONE:    if (bus.rsp_ready && r_rsp_valid) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // State register plus control outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_pulse     <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_req_ready <= (w_state_d == IDLE);
      r_busy      <= (w_state_d != IDLE);
      r_pulse     <= (w_state_d == PULSE);
      r_rsp_valid <= (w_state_d == DONE);
      if (!w_timed || (w_state_d != r_state)) r_phase <= '0;
      else                                    r_phase <= r_phase + PH_W'(1);
    end
  end

  // Per-bit vote arithmetic on the count including the bit being sampled now
  always_comb begin
    w_maj      = '0;
    w_unst     = '0;
    w_cnt_next = '{default: '0};
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_cnt_next[i] = r_cnt[i] + CNT_W'(w_resp_sync[i]);
      w_maj[i]      = (w_cnt_next[i] > CNT_W'(NUM_EVAL / 2));
      w_unst[i]     = (w_cnt_next[i] != '0) && (w_cnt_next[i] != CNT_W'(NUM_EVAL));
    end
  end

  // Challenge latch, ones counters, eval counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_challenge    <= '0;
      r_eval         <= '0;
      r_rsp_data     <= '0;
      r_rsp_unstable <= '0;
      for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= '0;
    end else if (w_accept) begin
      r_challenge <= bus.req_challenge;
      r_eval      <= '0;
      for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= '0;
    end else if (r_state == SAMPLE) begin
      r_eval <= r_eval + CNT_W'(1);
      for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= w_cnt_next[i];
      if (w_last) begin
        r_rsp_data     <= w_maj;
        r_rsp_unstable <= w_unst;
      end
    end
  end

  assign puf_challenge    = r_challenge;
  assign puf_pulse        = r_pulse;
  assign busy             = r_busy;
  assign bus.req_ready    = r_req_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.rsp_unstable = r_rsp_unstable;

endmodule

// File: tb/tb_papuf_eval_ctrl.sv
// Directed bench for papuf_eval_ctrl with a behavioural PUF response model.
module tb_papuf_eval_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] puf_challenge;
  logic        puf_pulse;
  logic [15:0] puf_response;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int mode       = 0;
  int noisy_base = 0;

  int pulse_cnt = 0;
  int bad_width = 0;
  int valid_cnt = 0;
  int viol      = 0;
  int width_run = 0;
  logic        prev_busy  = 1'b0;
  logic        prev_pulse = 1'b0;
  logic [15:0] prev_chal  = '0;

  papuf_eval_ctrl_if #(.WIDTH(16)) bus ();

  papuf_eval_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .puf_challenge (puf_challenge),
    .puf_pulse     (puf_pulse),
    .puf_response  (puf_response),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // PUF model: response selected by mode; noisy mode varies per pulse index
  always @* begin
    case (mode)
      1:       puf_response = {((pulse_cnt - noisy_base) == 3), 14'd0,
                               (((pulse_cnt - noisy_base) % 2) == 1)};
      2:       puf_response = 16'h5A5A;
      default: puf_response = 16'hA5C3;
    endcase
  end

  // Monitor: pulse count/width, rsp_valid cycles, challenge stability
  always @(negedge clk) begin
    if (puf_pulse) begin
      if (!prev_pulse) begin
        pulse_cnt = pulse_cnt + 1;
        width_run = 1;
      end else begin
        width_run = width_run + 1;
      end
    end else if (prev_pulse && width_run != 4) begin
      bad_width = bad_width + 1;
    end
    if (bus.rsp_valid) valid_cnt = valid_cnt + 1;
    if (((prev_busy && busy) || (prev_pulse && puf_pulse)) && (puf_challenge !== prev_chal))
      viol = viol + 1;
    prev_pulse = puf_pulse;
    prev_busy  = busy;
    prev_chal  = puf_challenge;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      errors = errors + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for req_ready, hand over a challenge, return cycles until rsp_valid
  task automatic run_req(input logic [15:0] chal, output int lat);
    int n;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid     = 1'b1;
    bus.req_challenge = chal;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pbase;
    int bbase;
    int vbase;
    int rises;
    int n;
    logic prevp;

    bus.req_valid     = 1'b0;
    bus.req_challenge = '0;
    bus.rsp_ready     = 1'b1;
    rst_n             = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulse", 32'(puf_pulse), 32'd0);
    check("rst_challenge", 32'(puf_challenge), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    check("rst_rsp_unstable", 32'(bus.rsp_unstable), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stable PUF
    mode  = 0;
    pbase = pulse_cnt;
    bbase = bad_width;
    run_req(16'h1234, lat);
    check("stable_latency", 32'(lat), 32'd76);
    check("stable_data", 32'(bus.rsp_data), 32'h0000A5C3);
    check("stable_unstable", 32'(bus.rsp_unstable), 32'h0);
    check("stable_challenge", 32'(puf_challenge), 32'h00001234);
    check("stable_pulse_count", 32'(pulse_cnt - pbase), 32'd5);
    check("stable_pulse_width", 32'(bad_width - bbase), 32'd0);
    @(posedge clk); #1;
    check("stable_valid_drop", 32'(bus.rsp_valid), 32'd0);
    check("stable_idle_ready", 32'(bus.req_ready), 32'd1);
    check("stable_idle_busy", 32'(busy), 32'd0);

    // Noisy PUF
    mode       = 1;
    noisy_base = pulse_cnt;
    run_req(16'h0F0F, lat);
    check("noisy_latency", 32'(lat), 32'd76);
    check("noisy_data", 32'(bus.rsp_data), 32'h00000001);
    check("noisy_unstable", 32'(bus.rsp_unstable), 32'h00008001);
    @(posedge clk); #1;

    // Backpressure with an ignored request in the window
    mode          = 2;
    bus.rsp_ready = 1'b0;
    run_req(16'h00FF, lat);
    check("bp_latency", 32'(lat), 32'd76);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_valid_held", 32'(bus.rsp_valid), 32'd1);
      check("bp_data_held", 32'(bus.rsp_data), 32'h00005A5A);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      if (i == 5) begin
        bus.req_valid     = 1'b1;
        bus.req_challenge = 16'hDEAD;
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_release_ready", 32'(bus.req_ready), 32'd1);
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_ignored_req", 32'(puf_challenge), 32'h000000FF);
    check("bp_data_kept", 32'(bus.rsp_data), 32'h00005A5A);

    // Back-to-back requests
    mode  = 0;
    bbase = bad_width;
    run_req(16'h0000, lat);
    check("b2b0_latency", 32'(lat), 32'd76);
    check("b2b0_data", 32'(bus.rsp_data), 32'h0000A5C3);
    run_req(16'hFFFF, lat);
    check("b2b1_latency", 32'(lat), 32'd76);
    check("b2b1_challenge", 32'(puf_challenge), 32'h0000FFFF);
    run_req(16'h8001, lat);
    check("b2b2_latency", 32'(lat), 32'd76);
    check("b2b2_challenge", 32'(puf_challenge), 32'h00008001);
    check("b2b_pulse_width", 32'(bad_width - bbase), 32'd0);
    @(posedge clk); #1;

    // Reset during the third pulse
    mode = 2;
    n    = 0;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid     = 1'b1;
    bus.req_challenge = 16'h3C3C;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rises = 0;
    prevp = puf_pulse;
    n     = 0;
    while (rises < 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (puf_pulse && !prevp) rises++;
      prevp = puf_pulse;
    end
    check("midrst_third_pulse", 32'(rises), 32'd3);
    check("midrst_pulse_high", 32'(puf_pulse), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pulse_low", 32'(puf_pulse), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    vbase = valid_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("midrst_no_rsp", 32'(valid_cnt - vbase), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);
    run_req(16'h6E6E, lat);
    check("postrst_latency", 32'(lat), 32'd76);
    check("postrst_data", 32'(bus.rsp_data), 32'h00005A5A);
    check("postrst_unstable", 32'(bus.rsp_unstable), 32'h0);
    @(posedge clk); #1;

    check("challenge_stability", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
